rf_scoreboard: RTL and testbench

Parametrised register file with integrated write-pending scoreboard, successor to the single-cycle `RF` for the pipelined processor. Provides NRD combinational read ports with write-first bypass, one writeback port, a per-register in-flight write counter fed by ID issue and WB retire, flush of all pending state, and a debug read port. ID uses `rd_ready`/`iss_ready` to stall on RAW hazards and in-flight overflow.

---
 rtl/rf_pkg.sv | 13 +
 rtl/sb_counter.sv | 31 +++
 rtl/rf_scoreboard.sv | 96 +++++++++
 tb/tb_rf_scoreboard.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file / write-pending scoreboard.
package rf_pkg;

    localparam int          REG_AW       = 5;
    localparam int          XLEN_DEFAULT = 32;
    localparam logic [4:0]  ZERO_REG     = 5'd0;

    // Width of a counter that must hold values 0..maxinf.
    function automatic int cnt_width(input int maxinf);
        return $clog2(maxinf + 1);
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down in-flight write counter for one architectural register.
module sb_counter #(
    parameter int CW   = 2,
    parameter int MAXV = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          is_zero,
    output logic          is_one,
    output logic          is_max
);

    // Count issues up and retires down; simultaneous inc+dec cancel, ends saturate.
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (inc && !dec && cnt != CW'(MAXV))
            cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign is_zero = (cnt == '0);
    assign is_one  = (cnt == CW'(1));
    assign is_max  = (cnt == CW'(MAXV));

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with write-first bypass reads and a per-register in-flight
// write scoreboard used by ID to stall on RAW hazards.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NRD    = 2,
    parameter int MAXINF = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_AW*NRD-1:0] rd_addr,
    output logic [XLEN*NRD-1:0]   rd_data,
    output logic [NRD-1:0]        rd_ready,
    input  logic                  iss_valid,
    input  logic [REG_AW-1:0]     iss_rd,
    output logic                  iss_ready,
    input  logic                  wb_valid,
    input  logic [REG_AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    input  logic [REG_AW-1:0]     reg_sel,
    output logic [XLEN-1:0]       reg_data,
    output logic                  sb_err
);

    localparam int CW = cnt_width(MAXINF);

    logic [31:0][XLEN-1:0] regs;
    logic [31:0][CW-1:0]   cnt;
    logic [31:0]           is_zero, is_one, is_max;
    logic                  wb_en;
    logic                  iss_acc;

    // x0 is never pending and never full.
    assign cnt[0]     = '0;
    assign is_zero[0] = 1'b1;
    assign is_one[0]  = 1'b0;
    assign is_max[0]  = 1'b0;

    assign wb_en   = wb_valid && (wb_rd != ZERO_REG);
    // A writeback to the same register frees a slot this cycle, so a full
    // register can still accept an issue when it retires one simultaneously.
    assign iss_ready = !((iss_rd != ZERO_REG) && is_max[iss_rd] &&
                         !(wb_valid && wb_rd == iss_rd));
    assign iss_acc = iss_valid && iss_ready && !flush;

    for (genvar r = 1; r < 32; r++) begin : g_cnt
        logic hit_wb, hit_iss;
        assign hit_wb  = wb_valid && (wb_rd == REG_AW'(r));
        assign hit_iss = iss_acc && (iss_rd == REG_AW'(r));
        sb_counter #(.CW(CW), .MAXV(MAXINF)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (hit_iss),
            .dec     (hit_wb && cnt[r] != '0),
            .clr     (flush),
            .cnt     (cnt[r]),
            .is_zero (is_zero[r]),
            .is_one  (is_one[r]),
            .is_max  (is_max[r])
        );
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [REG_AW-1:0] a;
        logic              byp;
        assign a   = rd_addr[REG_AW*i +: REG_AW];
        assign byp = wb_valid && (wb_rd == a) && (a != ZERO_REG);
        assign rd_data[XLEN*i +: XLEN] = byp ? wb_data :
                                         (a == ZERO_REG) ? '0 : regs[a];
        // Final when nothing older is outstanding, or the last one retires now.
        assign rd_ready[i] = (a == ZERO_REG) || is_zero[a] ||
                             (is_one[a] && wb_valid && wb_rd == a);
    end

    assign reg_data = (reg_sel == ZERO_REG) ? '0 : regs[reg_sel];

    // Register array write; x0 is left at its reset value forever.
    always_ff @(posedge clk) begin
        if (!rst_n)
            regs <= '0;
        else if (wb_en)
            regs[wb_rd] <= wb_data;
    end

    // Sticky flag for a retire with nothing pending; a flush makes such a
    // retire legitimate (the issue was just killed), so it is not flagged.
    always_ff @(posedge clk) begin
        if (!rst_n)
            sb_err <= 1'b0;
        else if (wb_en && cnt[wb_rd] == '0 && !flush)
            sb_err <= 1'b1;
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: per-cycle expected outputs from a
// behavioural model go through a queue and are compared against the DUT.
module tb_rf_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        sb_err;

    always #5 clk = ~clk;

    rf_scoreboard #(.XLEN(32), .NRD(2), .MAXINF(3)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_ready(rd_ready), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .reg_sel(reg_sel),
        .reg_data(reg_data), .sb_err(sb_err)
    );

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs[32];
    int          mcnt[32];
    logic        merr;
    int          errs   = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] act_of(input int kind);
        case (kind)
            0: return rd_data[31:0];
            1: return rd_data[63:32];
            2: return {30'd0, rd_ready};
            3: return {31'd0, iss_ready};
            4: return reg_data;
            default: return {31'd0, sb_err};
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_valid && wb_rd == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic logic exp_rdy(input logic [4:0] a);
        return (a == 0) || (mcnt[a] == 0) || (mcnt[a] == 1 && wb_valid && wb_rd == a);
    endfunction

    function automatic logic exp_issr();
        return !(iss_rd != 0 && mcnt[iss_rd] == 3 && !(wb_valid && wb_rd == iss_rd));
    endfunction

    task automatic idle();
        iss_valid = 0; iss_rd = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
    endtask

    // One clock: check combinational outputs mid-cycle, then advance model.
    task automatic step(input bit chk);
        logic acc, issr, wbdec;
        @(negedge clk);
        if (chk) begin
            q.push_back('{"rd_data0", 0, exp_rd(rd_addr[4:0])});
            q.push_back('{"rd_data1", 1, exp_rd(rd_addr[9:5])});
            q.push_back('{"rd_ready", 2, {30'd0, exp_rdy(rd_addr[9:5]), exp_rdy(rd_addr[4:0])}});
            q.push_back('{"iss_ready", 3, {31'd0, exp_issr()}});
            q.push_back('{"reg_data", 4, (reg_sel == 0) ? 32'd0 : mregs[reg_sel]});
            q.push_back('{"sb_err", 5, {31'd0, merr}});
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check(e.tag, act_of(e.kind), e.exp);
            end
        end
        issr = exp_issr();
        @(posedge clk);
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin mregs[r] = 0; mcnt[r] = 0; end
            merr = 0;
        end else begin
            acc   = iss_valid && issr && !flush;
            wbdec = 0;
            if (wb_valid && wb_rd != 0) begin
                if (mcnt[wb_rd] == 0 && !flush) merr = 1;
                wbdec = (mcnt[wb_rd] > 0);
                mregs[wb_rd] = wb_data;
            end
            if (flush) begin
                for (int r = 0; r < 32; r++) mcnt[r] = 0;
            end else begin
                if (acc && iss_rd != 0) mcnt[iss_rd]++;
                if (wbdec) mcnt[wb_rd]--;
            end
        end
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        idle(); iss_valid = 1; iss_rd = r; step(1);
    endtask

    task automatic wback(input logic [4:0] r, input logic [31:0] d);
        idle(); wb_valid = 1; wb_rd = r; wb_data = d; step(1);
    endtask

    initial begin
        idle();
        rst_n = 0; rd_addr = 0; reg_sel = 0; merr = 0;
        for (int r = 0; r < 32; r++) begin mregs[r] = 0; mcnt[r] = 0; end
        step(0);
        rst_n = 1;
        step(1);                                   // reset state

        // write x5, bypass then array
        rd_addr = {5'd0, 5'd5}; reg_sel = 5;
        issue(5);
        wback(5, 32'hDEADBEEF);
        idle(); step(1);
        rd_addr = {5'd5, 5'd0}; reg_sel = 0;
        wback(0, 32'h0000_0123);                   // x0 stays 0
        idle(); step(1);

        // RAW on x7
        rd_addr = {5'd5, 5'd7}; reg_sel = 7;
        issue(7);
        idle(); step(1);
        wback(7, 32'h12);
        idle(); step(1);

        // fill x9 to MAXINF, then issue with same-cycle retire
        rd_addr = {5'd9, 5'd9}; reg_sel = 9;
        issue(9); issue(9); issue(9);
        idle(); iss_rd = 9; step(1);               // full, iss_valid low
        iss_valid = 1; step(1);                    // rejected
        idle(); iss_valid = 1; iss_rd = 9; wb_valid = 1; wb_rd = 9; wb_data = 32'h99; step(1);
        idle(); iss_rd = 9; step(1);

        // flush with pending x3, writeback commits, discarded issue of x6
        rd_addr = {5'd6, 5'd3}; reg_sel = 3;
        issue(3); issue(3);
        idle(); flush = 1; wb_valid = 1; wb_rd = 3; wb_data = 32'hAA; iss_valid = 1; iss_rd = 6; step(1);
        idle(); step(1);

        // retire with nothing pending -> sticky error
        rd_addr = {5'd3, 5'd4}; reg_sel = 4;
        wback(4, 32'h44);
        idle(); step(1); step(1);

        // random traffic on a small register pool
        for (int n = 0; n < 300; n++) begin
            logic [4:0] pool[5];
            pool[0] = 0; pool[1] = 1; pool[2] = 2; pool[3] = 3; pool[4] = 31;
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_rd    = pool[$urandom_range(0, 4)];
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_rd     = pool[$urandom_range(0, 4)];
            wb_data   = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            rd_addr   = {pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)]};
            reg_sel   = pool[$urandom_range(0, 4)];
            step(1);
        end

        // mid-stream reset with pending counts and a writeback in flight
        idle(); rd_addr = {5'd10, 5'd11}; reg_sel = 10;
        issue(10); issue(11); issue(11);
        idle(); rst_n = 0; wb_valid = 1; wb_rd = 10; wb_data = 32'hCAFE; iss_valid = 1; iss_rd = 11; step(1);
        idle(); rst_n = 1; step(1);
        step(1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
